bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3 / double dabble); inverse of the divider's BCD-to-binary input stage.
//  Takes a binary result (quotient or remainder) and produces packed BCD digits for the 7-segment display path.
//  One bit processed per clock; start/busy/done handshake matches the divider's start-pulse style.
// PARAMETERS
//  W_BIN     8  width of binary input
//  N_DIGITS  3  number of BCD output digits; must satisfy 10**N_DIGITS > 2**W_BIN-1
// PORTS
//  clk      in   1            system clock, rising edge
//  rst_n    in   1            asynchronous active-low reset
//  start    in   1            one-cycle request; bin_in sampled on the same edge
//  bin_in   in   W_BIN        unsigned binary value to convert
//  busy     out  1            conversion in progress
//  done     out  1            one-cycle pulse: bcd_out valid and updated
//  bcd_out  out  4*N_DIGITS   packed BCD {hundreds, tens, units}, units in [3:0]
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, busy=0, done=0, bcd_out=0, scratch and counter=0.
//  States: IDLE -> SHIFT -> IDLE (done pulsed on exit from SHIFT).
//  IDLE: start=1 at edge E0 -> load shift reg {N_DIGITS*4'h0, bin_in}, cnt=W_BIN, busy=1, enter SHIFT.
//  SHIFT: each edge, every BCD nibble >=5 gets +3, then whole register shifts left 1; cnt decrements.
//  After W_BIN shift edges (E1..E_W_BIN), the next edge E_{W_BIN+1} copies BCD field to bcd_out,
//   done=1 for exactly one cycle, busy=0, state=IDLE. Latency start->done = W_BIN+1 edges (9 at default).
//  start while busy=1: ignored, no queueing, bin_in not resampled.
//  start in the cycle done=1: accepted (back-to-back, state already IDLE).
//  bcd_out holds the last result between conversions; never shows intermediate values.
//  Nibble add: 4-bit, values <=9 guaranteed by algorithm; nibble result of add-3 never exceeds 4'hC before shift.
//  rst_n asserted mid-conversion: conversion abandoned, no done pulse, outputs to reset values immediately.
//  Parameter check: simulation-only $fatal at elaboration if 10**N_DIGITS <= 2**W_BIN-1.
// CONFIGURATION
//  BIN2BCD_LEADING_BLANK_EN defined: leading zero digits of bcd_out replaced by BCD_BLANK (4'hF);
//   units digit never blanked (value 0 -> 4'hF,4'hF,4'h0). Applied at the copy into bcd_out.
//  Not defined: plain BCD, leading zeros output as 4'h0.
//  Blank code 4'hF matches the display/input convention where 4'b1111 means "empty digit".
// STRUCTURE
//  bcd_pkg: BCD_BLANK = 4'hF, BCD_ADJ_THR = 4'd5, BCD_ADJ_ADD = 4'd3, state enum typedef
//   b2b_state_t {B2B_IDLE, B2B_SHIFT}, function to compute counter width $clog2(W_BIN+1).
//  One sub-module: bcd_digit_adj (combinational nibble: out = in>=5 ? in+3 : in), instantiated N_DIGITS times.
//  Top holds FSM, counter, shift register, output register and optional blanking logic.
// TESTING
//  Reset: hold rst_n=0 3 cycles -> busy=0, done=0, bcd_out=12'h000.
//  bin_in=8'd15, start pulse -> done exactly 9 edges later, bcd_out=12'h015 (blank EN: 12'hF15).
//  bin_in=8'd255 -> bcd_out=12'h255; bin_in=8'd0 -> 12'h000 (blank EN: 12'hFF0).
//  bin_in=8'd100, then start with bin_in=8'd7 at edge 3 while busy -> ignored, result 12'h100, one done only.
//  Back-to-back: start with 8'd42 in the done cycle of previous conversion -> 12'h042 after 9 more edges.
//  rst_n pulsed low at edge 4 of conversion of 8'd199 -> no done, bcd_out=0; next start 8'd9 -> 12'h009.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and sizing helper for the binary-to-BCD converter.
package bcd_pkg;

    localparam logic [3:0] BCD_BLANK   = 4'hF;
    localparam logic [3:0] BCD_ADJ_THR = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD = 4'd3;

    typedef enum logic {
        B2B_IDLE,
        B2B_SHIFT
    } b2b_state_t;

    function automatic int cnt_width(input int w_bin);
        return $clog2(w_bin + 1);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble nibble correction: digits of 5 or more get +3 ahead of the shift.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] nib,
    output logic [3:0] nib_adj
);

    assign nib_adj = (nib >= BCD_ADJ_THR) ? nib + BCD_ADJ_ADD : nib;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock with start/busy/done handshake.
// Define BIN2BCD_LEADING_BLANK_EN to replace leading zero digits with BCD_BLANK.
//
// state     | meaning
// B2B_IDLE  | waiting for start; bcd_out holds last result
// B2B_SHIFT | adjust+shift while cnt != 0, then publish result
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int W_BIN    = 8,
    parameter int N_DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [W_BIN-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*N_DIGITS-1:0] bcd_out
);

    localparam int BW = 4 * N_DIGITS;
    localparam int SW = BW + W_BIN;
    localparam int CW = cnt_width(W_BIN);

    generate
        if (10 ** N_DIGITS <= 2 ** W_BIN - 1) begin : g_param_err
            $fatal(1, "bin2bcd_seq: N_DIGITS too small for W_BIN");
        end
    endgenerate

    b2b_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [SW-1:0] scratch, scratch_nxt, adj;
    logic [BW-1:0] bcd_nxt;
    logic          done_nxt;

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .nib     (scratch[W_BIN+4*g +: 4]),
            .nib_adj (adj[W_BIN+4*g +: 4])
        );
    end
    assign adj[W_BIN-1:0] = scratch[W_BIN-1:0];

    function automatic logic [BW-1:0] finalize(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
`ifdef BIN2BCD_LEADING_BLANK_EN
        begin
            logic lead;
            lead = 1'b1;
            // Units digit is never blanked so a zero value still shows "0".
            for (int i = N_DIGITS - 1; i >= 1; i--) begin
                if (lead && (v[4*i +: 4] == 4'h0)) begin
                    r[4*i +: 4] = BCD_BLANK;
                end else begin
                    lead = 1'b0;
                end
            end
        end
`endif
        return r;
    endfunction

    assign busy = (state == B2B_SHIFT);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        scratch_nxt = scratch;
        bcd_nxt     = bcd_out;
        done_nxt    = 1'b0;
        case (state)
            B2B_IDLE: begin
                if (start) begin
                    scratch_nxt = {{BW{1'b0}}, bin_in};
                    cnt_nxt     = CW'(W_BIN);
                    state_nxt   = B2B_SHIFT;
                end
            end
            B2B_SHIFT: begin
                if (cnt != '0) begin
                    scratch_nxt = adj << 1;
                    cnt_nxt     = cnt - CW'(1);
                end else begin
                    bcd_nxt   = finalize(scratch[SW-1:W_BIN]);
                    done_nxt  = 1'b1;
                    state_nxt = B2B_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= B2B_IDLE;
            cnt     <= '0;
            scratch <= '0;
            bcd_out <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            scratch <= scratch_nxt;
            bcd_out <= bcd_nxt;
            done    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: scoreboard of expected results checked on each done pulse.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  bin_in = 8'd0;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;

    int compared   = 0;
    int mismatched = 0;
    int edge_cnt   = 0;

    typedef struct {
        logic [11:0] bcd;
        int          start_edge;
    } exp_t;

    exp_t        sb[$];
    logic [11:0] last_exp = 12'h000;

    bin2bcd_seq #(.W_BIN(8), .N_DIGITS(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [11:0] model(input int v);
        logic [11:0] r;
        r = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
`ifdef BIN2BCD_LEADING_BLANK_EN
        if (r[11:8] == 4'h0) begin
            r[11:8] = 4'hF;
            if (r[7:4] == 4'h0) r[7:4] = 4'hF;
        end
`endif
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            compared++;
            assert (sb.size() != 0) else begin
                mismatched++;
                $error("FAIL unexpected_done: observed done with empty scoreboard, expected no done");
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                compared++;
                assert (bcd_out === e.bcd) else begin
                    mismatched++;
                    $error("FAIL bcd_value: observed %h expected %h", bcd_out, e.bcd);
                end
                compared++;
                assert (edge_cnt - e.start_edge === 9) else begin
                    mismatched++;
                    $error("FAIL latency: observed %0d expected 9", edge_cnt - e.start_edge);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Called right after a negedge: start is sampled on the coming posedge.
    task automatic issue(input int v, input bit expect_result);
        exp_t e;
        bin_in = 8'(v);
        start  = 1'b1;
        if (expect_result) begin
            e.bcd        = model(v);
            e.start_edge = edge_cnt + 1;
            sb.push_back(e);
            last_exp = e.bcd;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        compared++;
        assert (sb.size() == 0) else begin
            mismatched++;
            $error("FAIL %s: observed %0d pending results, expected 0", tag, sb.size());
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_busy", 12'(busy), 12'h0);
        check("reset_done", 12'(done), 12'h0);
        check("reset_bcd", bcd_out, 12'h000);
        rst_n = 1'b1;
        @(negedge clk);

        issue(15, 1'b1);
        wait_drain("drain_15");
        @(negedge clk);
        issue(255, 1'b1);
        wait_drain("drain_255");
        issue(0, 1'b1);
        wait_drain("drain_0");

        // Start while busy must be ignored and must not disturb bcd_out.
        issue(100, 1'b1);
        @(negedge clk);
        check("busy_mid", 12'(busy), 12'h1);
        check("hold_mid", bcd_out, model(0));
        issue(7, 1'b0);
        wait_drain("drain_100");
        repeat (12) @(negedge clk);

        // Back-to-back: new start issued in the done cycle.
        issue(50, 1'b1);
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        check("b2b_done_seen", 12'(done), 12'h1);
        issue(42, 1'b1);
        wait_drain("drain_42");

        // Reset in the middle of a conversion.
        issue(199, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 12'(busy), 12'h0);
        check("rst_mid_done", 12'(done), 12'h0);
        check("rst_mid_bcd", bcd_out, 12'h000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("rst_no_done_bcd", bcd_out, 12'h000);

        issue(9, 1'b1);
        wait_drain("drain_9");
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
